row_request_arbiter: RTL
========================

ROW_REQUEST_ARBITER -- requirements
Module: row_request_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 16: credit limit on unfulfilled row-requests.
REQ-002 SHALL have parameter DW, default 256: stream data width.
REQ-003 SHALL have one clock; reset is synchronous and active-low: clk  input  1  rising-edge clock.
REQ-004 SHALL have resetn  input  1  synchronous active-low reset.
REQ-005 SHALL have S0_AXIS_TDATA/TVALID/TLAST  input  DW/1/1, S0_AXIS_TREADY  output  1: requester-0 row-request stream.
REQ-006 SHALL have S1_AXIS_TDATA/TVALID/TLAST  input  DW/1/1, S1_AXIS_TREADY  output  1: requester-1 row-request stream.
REQ-007 SHALL have M_AXIS_TDATA/TVALID/TLAST  output  DW/1/1, M_AXIS_TREADY  input  1: merged stream to ECD-Master.
REQ-008 SHALL have row_complete_in  input  1: one-cycle pulse per fulfilled row.
REQ-009 SHALL have outstanding  output  8: current unfulfilled-request count.
REQ-010 SHALL have grant_id  output  1: source of the beat currently held on M_AXIS.
REQ-011 SHALL have underflow_err  output  1: sticky; row_complete_in seen with outstanding==0.
REQ-012 SHALL have clear_err  input  1: pulse clears underflow_err.

Function
REQ-013 SHALL run a two-state machine: IDLE (M_AXIS_TVALID=0) and SEND (M_AXIS_TVALID=1).
REQ-014 In IDLE, SHALL accept a beat only when outstanding < MAX_OUTSTANDING and at least one S*_AXIS_TVALID is high.
REQ-015 Accept SHALL assert the winner's TREADY combinationally that cycle, register its TDATA/TLAST and its index into grant_id, and enter SEND; the loser's TREADY stays 0.
REQ-016 Arbitration SHALL be round-robin: if both valid, grant the index != last_grant; if one valid, grant it.
REQ-017 last_grant SHALL update to grant_id on each M_AXIS handshake.
REQ-018 In SEND, M_AXIS_TDATA/TLAST/grant_id SHALL be held stable until M_AXIS_TREADY; on handshake SHALL return to IDLE.
REQ-019 Each source SHALL therefore see its data on M_AXIS one cycle after its accept; peak throughput is one beat per two cycles.
REQ-020 S*_AXIS_TREADY SHALL be 0 in SEND and whenever credit is exhausted.
REQ-021 outstanding SHALL increment on M_AXIS handshake, decrement on row_complete_in, and hold if both occur in one cycle.
REQ-022 row_complete_in with outstanding==0 and no same-cycle handshake SHALL leave outstanding at 0 and set underflow_err.
REQ-023 outstanding SHALL never exceed MAX_OUTSTANDING; MAX_OUTSTANDING SHALL be <= 255.
REQ-024 clear_err SHALL clear underflow_err, except that a same-cycle new underflow SHALL win (flag stays set).
REQ-025 TLAST SHALL pass through unmodified with its beat; the block does not interpret TDATA.

Reset
REQ-026 While resetn==0 SHALL force: state IDLE, M_AXIS_TVALID=0, S0/S1 TREADY=0, outstanding=0, underflow_err=0, grant_id=0, last_grant=1 (requester 0 wins first tie).
REQ-027 Reset asserted during SEND SHALL drop the held beat without completing a handshake.
REQ-028 M_AXIS_TDATA/TLAST need no reset value.

Structure
REQ-029 MAX_OUTSTANDING default and packet-field offsets (PKT_TYPE_OFFS=0, ROW_REQ_OFFS=8) SHALL live in the shared ECD constants package, not in this module.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last_grant; outputs gnt_valid, gnt_id); the rest is flat.

Verification
REQ-031 Only S0 valid, 3 beats with TDATA[39:8]=C008..C00A, M_AXIS_TREADY=1 -> M_AXIS emits C008,C009,C00A in order, grant_id=0, outstanding=3.
REQ-032 S0 and S1 both continuously valid from reset, 6 beats accepted -> grant order 0,1,0,1,0,1.
REQ-033 MAX_OUTSTANDING=16, no row_complete_in, both valid -> exactly 16 handshakes, then TREADY=0 on both; one row_complete_in pulse -> exactly one more beat accepted.
REQ-034 M_AXIS_TREADY held low 10 cycles in SEND -> TVALID stays 1, TDATA/grant_id unchanged, both S TREADY=0, outstanding unchanged.
REQ-035 outstanding=4, handshake and row_complete_in in same cycle -> outstanding stays 4; row_complete_in at outstanding=0 -> stays 0, underflow_err=1 until clear_err.
REQ-036 resetn low for one cycle while in SEND with outstanding=7 -> next cycle TVALID=0, outstanding=0; next tie grants requester 0.

Source files
------------

// File: rtl/row_request_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// row_request_arbiter_pkg
// Shared ECD constants: default credit limit, row-request packet field
// offsets, and the arbiter FSM state type.
// ---------------------------------------------------------------------------
package row_request_arbiter_pkg;

   // Default number of row requests that may be in flight toward ECD-Master.
   // The outstanding counter is 8 bits wide, so a limit must not exceed 255.
   localparam int unsigned MAX_OUTSTANDING_DEF = 16;
   localparam int unsigned OUTSTANDING_W       = 8;

   // Row-request packet layout (bit offsets within TDATA).
   localparam int unsigned PKT_TYPE_OFFS = 0;
   localparam int unsigned ROW_REQ_OFFS  = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,  // M_AXIS empty, may accept from a requester
      ST_SEND = 1'b1   // one beat held on M_AXIS until handshake
   } arb_state_e;

endpackage

// File: rtl/row_request_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin selector (purely combinational).
//   req[1:0]   in  : request vector
//   last_grant in  : index granted most recently
//   gnt_valid  out : at least one request present
//   gnt_id     out : winning index
// ---------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_valid,
   output logic       gnt_id
);

   always_comb begin
      gnt_valid = |req;
      // On a tie the requester that did not win last time gets the slot;
      // otherwise whichever one is asking (req[1] alone -> 1, req[0] alone -> 0).
      if (req == 2'b11) gnt_id = ~last_grant;
      else              gnt_id = req[1];
   end

endmodule

// File: rtl/row_request_arbiter.sv
// ---------------------------------------------------------------------------
// row_request_arbiter
// Merges two AXI-Stream row-request sources into one stream to ECD-Master,
// round-robin, with a credit limit on requests not yet fulfilled.
//   clk, resetn                 : clock, synchronous active-low reset
//   S0_AXIS_* / S1_AXIS_*       : requester streams (TDATA/TVALID/TLAST in,
//                                 TREADY out)
//   M_AXIS_*                    : merged stream (TDATA/TVALID/TLAST out,
//                                 TREADY in)
//   row_complete_in             : one-cycle pulse per fulfilled row
//   outstanding                 : handshaken but unfulfilled request count
//   grant_id                    : source of the beat held on M_AXIS
//   underflow_err / clear_err   : sticky completion-underflow flag and clear
// Throughput is one beat per two cycles: a beat is captured in IDLE and
// presented from the register in SEND, so nothing combinational crosses
// from a slave TVALID to the master side.
// ---------------------------------------------------------------------------
module row_request_arbiter
   import row_request_arbiter_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
   parameter int unsigned DW              = 256
) (
   input  logic          clk,
   input  logic          resetn,

   input  logic [DW-1:0] S0_AXIS_TDATA,
   input  logic          S0_AXIS_TVALID,
   input  logic          S0_AXIS_TLAST,
   output logic          S0_AXIS_TREADY,

   input  logic [DW-1:0] S1_AXIS_TDATA,
   input  logic          S1_AXIS_TVALID,
   input  logic          S1_AXIS_TLAST,
   output logic          S1_AXIS_TREADY,

   output logic [DW-1:0] M_AXIS_TDATA,
   output logic          M_AXIS_TVALID,
   output logic          M_AXIS_TLAST,
   input  logic          M_AXIS_TREADY,

   input  logic          row_complete_in,
   output logic [7:0]    outstanding,
   output logic          grant_id,
   output logic          underflow_err,
   input  logic          clear_err
);

   localparam logic [OUTSTANDING_W-1:0] MAX_CNT = OUTSTANDING_W'(MAX_OUTSTANDING);

   arb_state_e             state_q, state_d;
   logic [DW-1:0]          data_q, data_d;
   logic                   last_q, last_d;
   logic                   grant_q, grant_d;
   logic                   last_grant_q, last_grant_d;
   logic [OUTSTANDING_W-1:0] outst_q, outst_d;
   logic                   err_q, err_d;

   logic gnt_valid, gnt_id;
   logic credit_ok, accept, m_hs, underflow;

   rr_arbiter2 u_rr (
      .req        ({S1_AXIS_TVALID, S0_AXIS_TVALID}),
      .last_grant (last_grant_q),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      last_d       = last_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      outst_d      = outst_q;
      err_d        = err_q;

      credit_ok = (outst_q < MAX_CNT);
      // resetn gates every combinational output so nothing handshakes while
      // reset is held, even though the state itself only clears at the edge.
      accept    = resetn && (state_q == ST_IDLE) && credit_ok && gnt_valid;
      m_hs      = resetn && (state_q == ST_SEND) && M_AXIS_TREADY;
      underflow = row_complete_in && !m_hs && (outst_q == '0);

      S0_AXIS_TREADY = accept && !gnt_id;
      S1_AXIS_TREADY = accept &&  gnt_id;
      M_AXIS_TVALID  = resetn && (state_q == ST_SEND);

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               data_d  = gnt_id ? S1_AXIS_TDATA : S0_AXIS_TDATA;
               last_d  = gnt_id ? S1_AXIS_TLAST : S0_AXIS_TLAST;
               grant_d = gnt_id;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (m_hs) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Credit accounting. A handshake can only follow an accept made with
      // outst_q < MAX_CNT, and outst_q cannot grow while in SEND, so the
      // increment never passes the limit.
      if (m_hs && !row_complete_in)
         outst_d = outst_q + 1'b1;
      else if (!m_hs && row_complete_in && (outst_q != '0))
         outst_d = outst_q - 1'b1;

      // A new underflow in the same cycle as clear_err keeps the flag set.
      if (underflow)      err_d = 1'b1;
      else if (clear_err) err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;   // requester 0 wins the first tie
         outst_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         outst_q      <= outst_d;
         err_q        <= err_d;
      end
   end

   // Beat payload carries no reset; it is only observed while TVALID is high.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      last_q <= last_d;
   end

   assign M_AXIS_TDATA  = data_q;
   assign M_AXIS_TLAST  = last_q;
   assign grant_id      = grant_q;
   assign outstanding   = outst_q;
   assign underflow_err = err_q;

endmodule
